fan_tach_sensor: RTL

//  Measures fan speed from the open-drain tachometer line.

---
 rtl/fan_ctrl_pkg.sv | 18 +
 rtl/tach_debounce.sv | 43 ++++
 rtl/fan_tach_sensor.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fan_ctrl_pkg.sv
// Shared types and sizing helpers for the fan tachometer sensor.
package fan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } tach_state_e;

  localparam int unsigned DEFAULT_ADC_BITWIDTH = 8;

  // One spare bit above the scaled range lets saturation be detected before clipping.
  function automatic int unsigned pulse_cnt_width(input int unsigned adc_bits,
                                                  input int unsigned shift);
    return adc_bits + shift + 1;
  endfunction

endpackage

// File: rtl/tach_debounce.sv
// Tach input conditioning: 2-flop synchronizer, debounce, and a one-cycle pulse per debounced rising edge.
module tach_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tach_i,
  output logic pulse_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] stable_cnt_q;
  logic          level_q;
  logic          pulse_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q       <= '0;
      stable_cnt_q <= '0;
      level_q      <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], tach_i};
      pulse_q <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (stable_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_q      <= sync_q[1];
          stable_cnt_q <= '0;
          pulse_q      <= sync_q[1];
        end else begin
          stable_cnt_q <= stable_cnt_q + CW'(1);
        end
      end else begin
        stable_cnt_q <= '0;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/fan_tach_sensor.sv
// Fan speed sensor: counts debounced tach pulses per gate window and strobes one sample per window.
// Optional macro TACH_AVG_EN: report the average of the current and previous window values.
module fan_tach_sensor
  import fan_ctrl_pkg::*;
#(
  parameter int unsigned ADC_BITWIDTH    = DEFAULT_ADC_BITWIDTH,
  parameter int unsigned GATE_CYCLES     = 1000000,
  parameter int unsigned SCALE_SHIFT     = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    tach_i,
  output logic [ADC_BITWIDTH-1:0] speed_value_o,
  output logic                    sample_valid_o,
  output logic                    sat_o,
  output logic                    stall_o
);

  localparam int unsigned PW = pulse_cnt_width(ADC_BITWIDTH, SCALE_SHIFT);
  localparam int unsigned GW = $clog2(GATE_CYCLES);
  localparam logic [PW-1:0]           PMAX = '1;
  localparam logic [ADC_BITWIDTH-1:0] VMAX = '1;

  tach_state_e             state_q, state_d;
  logic [GW-1:0]           gate_q;
  logic [PW-1:0]           pulse_cnt_q;
  logic                    pulse;
  logic [PW-1:0]           scaled;
  logic                    over;
  logic [ADC_BITWIDTH-1:0] cur_val;

  tach_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tach_i (tach_i),
    .pulse_o(pulse)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    scaled  = pulse_cnt_q >> SCALE_SHIFT;
    over    = scaled > PW'(VMAX);
    cur_val = over ? VMAX : scaled[ADC_BITWIDTH-1:0];
    case (state_q)
      IDLE:    if (enable_i) state_d = MEASURE;
      MEASURE: begin
        if (!enable_i)                              state_d = IDLE;
        else if (gate_q == GW'(GATE_CYCLES - 1))    state_d = REPORT;
      end
      REPORT:  state_d = enable_i ? MEASURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The final MEASURE cycle still counts into its window; a pulse seen in REPORT seeds the next one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gate_q      <= '0;
      pulse_cnt_q <= '0;
    end else begin
      gate_q <= (state_q == MEASURE && state_d == MEASURE) ? gate_q + GW'(1) : '0;
      if (state_q == MEASURE && state_d != IDLE)
        pulse_cnt_q <= pulse_cnt_q + PW'(pulse && (pulse_cnt_q != PMAX));
      else if (state_q == REPORT && state_d == MEASURE)
        pulse_cnt_q <= PW'(pulse);
      else
        pulse_cnt_q <= '0;
    end
  end

`ifdef TACH_AVG_EN
  logic [ADC_BITWIDTH-1:0] prev_q;
  logic [ADC_BITWIDTH:0]   avg_sum;

  assign avg_sum = {1'b0, cur_val} + {1'b0, prev_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q         <= '0;
      speed_value_o  <= '0;
      sample_valid_o <= 1'b0;
      sat_o          <= 1'b0;
      stall_o        <= 1'b0;
    end else begin
      sample_valid_o <= (state_q == REPORT);
      if (state_q == REPORT) begin
        prev_q        <= cur_val;
        speed_value_o <= avg_sum[ADC_BITWIDTH:1];
        sat_o         <= over;
        stall_o       <= (pulse_cnt_q == '0);
      end
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      speed_value_o  <= '0;
      sample_valid_o <= 1'b0;
      sat_o          <= 1'b0;
      stall_o        <= 1'b0;
    end else begin
      sample_valid_o <= (state_q == REPORT);
      if (state_q == REPORT) begin
        speed_value_o <= cur_val;
        sat_o         <= over;
        stall_o       <= (pulse_cnt_q == '0);
      end
    end
  end
`endif

endmodule
